cacheline_adaptor: RTL and testbench

Bridges the cache's line-wide data array and the narrow burst memory bus. On a miss it fetches a full cache line as a fixed-length burst, assembles it, and presents it with a one-cycle write strobe and way index, ready to load straight into the data array. On a dirty eviction it serialises a line out as a burst. It sits between the cache controller / data array and main memory.

---
 rtl/cacheline_adaptor.sv | 111 +++++++++++
 tb/tb_cacheline_adaptor.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a line-wide cache data array and a narrow burst memory bus.
// Fills assemble BEATS beats into one line; writebacks serialise a latched line out.
module cacheline_adaptor #(
  parameter int block_size = 256,
  parameter int mem_width  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [31:0]           addr_i,
  input  logic [2:0]            way_i,
  input  logic [block_size-1:0] line_i,
  output logic                  resp_o,
  output logic [block_size-1:0] line_o,
  output logic                  load_o,
  output logic [2:0]            wr_addr_o,
  output logic [31:0]           address_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [mem_width-1:0]  burst_o,
  input  logic [mem_width-1:0]  burst_i,
  input  logic                  resp_i
);

  localparam int BEATS = block_size / mem_width;
  localparam int OFS   = $clog2(block_size / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [block_size-1:0] line_q, line_d;
  logic [31:0]           addr_q, addr_d;
  logic [2:0]            way_q, way_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      way_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
    end
  end

  // A read wins over a simultaneous write; the beat counter doubles as the slice index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    way_d   = way_q;
    unique case (state_q)
      IDLE: begin
        if (read_i || write_i) begin
          addr_d = {addr_i[31:OFS], {OFS{1'b0}}};
          way_d  = way_i;
          cnt_d  = '0;
          if (read_i) begin
            state_d = RD_BURST;
          end else begin
            state_d = WR_BURST;
            line_d  = line_i;
          end
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          line_d[cnt_q*mem_width +: mem_width] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = RD_DONE;
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = WR_DONE;
        end
      end
      RD_DONE:  state_d = IDLE;
      WR_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state alone, so no input reaches them combinationally.
  assign read_o    = (state_q == RD_BURST);
  assign write_o   = (state_q == WR_BURST);
  assign load_o    = (state_q == RD_DONE);
  assign resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
  assign line_o    = line_q;
  assign wr_addr_o = way_q;
  assign address_o = addr_q;
  assign burst_o   = (state_q == WR_BURST) ? line_q[cnt_q*mem_width +: mem_width] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: scoreboard bench for cacheline_adaptor fills, writebacks and reset.
module tb_cacheline_adaptor;

  localparam int BS    = 256;
  localparam int MW    = 64;
  localparam int BEATS = BS / MW;

  logic          clk;
  logic          rst;
  logic          read_i, write_i, resp_i;
  logic [31:0]   addr_i;
  logic [2:0]    way_i;
  logic [BS-1:0] line_i;
  logic [MW-1:0] burst_i;
  logic          resp_o, load_o, read_o, write_o;
  logic [BS-1:0] line_o;
  logic [2:0]    wr_addr_o;
  logic [31:0]   address_o;
  logic [MW-1:0] burst_o;

  int checks   = 0;
  int failures = 0;

  logic [BS-1:0] expLineQ[$];
  logic [2:0]    expWayQ[$];
  logic [MW-1:0] expBeatQ[$];

  localparam logic [BS-1:0] FILL_LINE = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

  cacheline_adaptor #(.block_size(BS), .mem_width(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .read_i    (read_i),
    .write_i   (write_i),
    .addr_i    (addr_i),
    .way_i     (way_i),
    .line_i    (line_i),
    .resp_o    (resp_o),
    .line_o    (line_o),
    .load_o    (load_o),
    .wr_addr_o (wr_addr_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BS-1:0] rand_line();
    logic [BS-1:0] r;
    for (int i = 0; i < BS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives one fill; the memory side answers beats from the line, with optional stalls.
  task automatic do_fill(input logic [31:0] addr, input logic [2:0] way,
                         input logic [BS-1:0] line, input int stall, input bit alsoWrite);
    logic [BS-1:0] expLine;
    logic [2:0]    expWay;
    logic [31:0]   expAddr;
    int beat, stallCnt, readCycles;
    bit done;
    @(negedge clk);
    read_i  = 1'b1;
    write_i = alsoWrite;
    addr_i  = addr;
    way_i   = way;
    line_i  = rand_line();
    resp_i  = 1'b0;
    expLineQ.push_back(line);
    expWayQ.push_back(way);
    expAddr    = {addr[31:5], 5'h00};
    beat       = 0;
    stallCnt   = 0;
    readCycles = 0;
    done       = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      addr_i = $urandom;
      way_i  = 3'($urandom);
      if (read_o) begin
        readCycles++;
        checks++;
        if (address_o !== expAddr) begin
          failures++;
          $display("[TB] FAIL fill_address got=%h exp=%h", address_o, expAddr);
        end
        checks++;
        if ({write_o, load_o, resp_o, burst_o} !== {3'b000, {MW{1'b0}}}) begin
          failures++;
          $display("[TB] FAIL fill_busy_outputs got wr=%b ld=%b rsp=%b bo=%h exp 0,0,0,0",
                   write_o, load_o, resp_o, burst_o);
        end
        if (stallCnt < stall) begin
          resp_i  = 1'b0;
          burst_i = {$urandom, $urandom};
          stallCnt++;
        end else if (beat < BEATS) begin
          resp_i  = 1'b1;
          burst_i = line[beat*MW +: MW];
          beat++;
          stallCnt = 0;
        end else begin
          resp_i = 1'b0;
        end
      end else if (resp_o) begin
        expLine = expLineQ.pop_front();
        expWay  = expWayQ.pop_front();
        checks++;
        if (load_o !== 1'b1) begin
          failures++;
          $display("[TB] FAIL fill_load got=%b exp=1", load_o);
        end
        checks++;
        if (line_o !== expLine) begin
          failures++;
          $display("[TB] FAIL fill_line got=%h exp=%h", line_o, expLine);
        end
        checks++;
        if (wr_addr_o !== expWay) begin
          failures++;
          $display("[TB] FAIL fill_way got=%0d exp=%0d", wr_addr_o, expWay);
        end
        checks++;
        if (readCycles != BEATS * (stall + 1)) begin
          failures++;
          $display("[TB] FAIL fill_read_cycles got=%0d exp=%0d", readCycles, BEATS * (stall + 1));
        end
        checks++;
        if (write_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL fill_done_write got=%b exp=0", write_o);
        end
        read_i  = 1'b0;
        write_i = 1'b0;
        resp_i  = 1'b0;
        done    = 1'b1;
      end else begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        checks++;
        if ({load_o, write_o} !== 2'b00) begin
          failures++;
          $display("[TB] FAIL fill_stray got ld=%b wr=%b exp 0,0", load_o, write_o);
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL fill_timeout got no resp_o exp resp_o within 200 cycles");
      read_i  = 1'b0;
      write_i = 1'b0;
      resp_i  = 1'b0;
    end
    @(negedge clk);
    checks++;
    if ({read_o, write_o, load_o, resp_o} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL fill_idle_after got=%b exp=0000", {read_o, write_o, load_o, resp_o});
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
    addr_i  = '0;
    way_i   = '0;
    line_i  = '0;
    burst_i = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({read_o, write_o, load_o, resp_o} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b exp=0000", {read_o, write_o, load_o, resp_o});
    end
    checks++;
    if ({address_o, wr_addr_o, line_o, burst_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data got addr=%h way=%0d line=%h bo=%h exp all 0",
               address_o, wr_addr_o, line_o, burst_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_fill_basic();
    do_fill(32'h0000_1234, 3'd5, FILL_LINE, 0, 1'b0);
  endtask

  task automatic test_idle_resp();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      resp_i  = cyc[0];
      burst_i = {$urandom, $urandom};
      checks++;
      if ({read_o, write_o, load_o, resp_o} !== 4'b0000 || line_o !== FILL_LINE) begin
        failures++;
        $display("[TB] FAIL idle_resp got ctrl=%b line=%h exp ctrl=0000 line=%h",
                 {read_o, write_o, load_o, resp_o}, line_o, FILL_LINE);
      end
    end
    resp_i = 1'b0;
    do_fill(32'h1000_00FF, 3'd2, rand_line(), 1, 1'b0);
  endtask

  // Writeback with two stall cycles before every beat; line_i is scrambled after acceptance.
  task automatic test_writeback();
    logic [BS-1:0] line;
    logic [31:0]   expAddr;
    logic [MW-1:0] dummy;
    int stallCnt, writeCycles;
    bit done;
    line    = rand_line();
    expAddr = 32'hABCD_EF40;
    @(negedge clk);
    write_i = 1'b1;
    read_i  = 1'b0;
    addr_i  = 32'hABCD_EF5C;
    way_i   = 3'd6;
    line_i  = line;
    resp_i  = 1'b0;
    for (int i = 0; i < BEATS; i++) expBeatQ.push_back(line[i*MW +: MW]);
    stallCnt    = 0;
    writeCycles = 0;
    done        = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      line_i  = rand_line();
      addr_i  = $urandom;
      burst_i = {$urandom, $urandom};
      if (write_o) begin
        writeCycles++;
        checks++;
        if (address_o !== expAddr || {read_o, load_o, resp_o} !== 3'b000) begin
          failures++;
          $display("[TB] FAIL wb_busy got addr=%h ctrl=%b exp addr=%h ctrl=000",
                   address_o, {read_o, load_o, resp_o}, expAddr);
        end
        if (expBeatQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL wb_extra_beat got write_o=1 exp write_o=0");
          resp_i = 1'b0;
        end else begin
          checks++;
          if (burst_o !== expBeatQ[0]) begin
            failures++;
            $display("[TB] FAIL wb_beat got=%h exp=%h", burst_o, expBeatQ[0]);
          end
          if (stallCnt < 2) begin
            resp_i = 1'b0;
            stallCnt++;
          end else begin
            resp_i   = 1'b1;
            dummy    = expBeatQ.pop_front();
            stallCnt = 0;
          end
        end
      end else if (resp_o) begin
        checks++;
        if (load_o !== 1'b0 || burst_o !== '0) begin
          failures++;
          $display("[TB] FAIL wb_done got ld=%b bo=%h exp ld=0 bo=0", load_o, burst_o);
        end
        checks++;
        if (expBeatQ.size() != 0 || writeCycles != BEATS * 3) begin
          failures++;
          $display("[TB] FAIL wb_count got left=%0d cycles=%0d exp left=0 cycles=%0d",
                   expBeatQ.size(), writeCycles, BEATS * 3);
        end
        write_i = 1'b0;
        resp_i  = 1'b0;
        done    = 1'b1;
      end else begin
        resp_i = 1'b0;
        checks++;
        if ({load_o, read_o, burst_o} !== {2'b00, {MW{1'b0}}}) begin
          failures++;
          $display("[TB] FAIL wb_stray got ld=%b rd=%b bo=%h exp 0,0,0", load_o, read_o, burst_o);
        end
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL wb_timeout got no resp_o exp resp_o within 200 cycles");
      write_i = 1'b0;
      resp_i  = 1'b0;
    end
    expBeatQ.delete();
    @(negedge clk);
    checks++;
    if ({read_o, write_o, load_o, resp_o} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL wb_idle_after got=%b exp=0000", {read_o, write_o, load_o, resp_o});
    end
  endtask

  task automatic test_read_write_priority();
    do_fill(32'h0000_0420, 3'd1, rand_line(), 0, 1'b1);
  endtask

  task automatic test_reset_midfill();
    @(negedge clk);
    read_i = 1'b1;
    addr_i = 32'hDEAD_BEEF;
    way_i  = 3'd3;
    resp_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
    end
    @(negedge clk);
    checks++;
    if (read_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midfill_busy got read_o=%b exp=1", read_o);
    end
    rst     = 1'b0;
    read_i  = 1'b0;
    resp_i  = 1'b0;
    #1;
    checks++;
    if ({read_o, write_o, load_o, resp_o} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset_ctrl got=%b exp=0000", {read_o, write_o, load_o, resp_o});
    end
    checks++;
    if ({address_o, wr_addr_o, line_o, burst_o} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset_data got addr=%h way=%0d line=%h exp all 0",
               address_o, wr_addr_o, line_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if ({read_o, write_o, load_o, resp_o} !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL post_reset_quiet got=%b exp=0000", {read_o, write_o, load_o, resp_o});
      end
    end
    do_fill(32'h0000_2000, 3'd4, rand_line(), 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_fill(32'h0000_8040, 3'd0, rand_line(), 0, 1'b0);
    do_fill(32'h0000_9FFF, 3'd7, rand_line(), 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_idle_resp();
    test_writeback();
    test_read_write_priority();
    test_reset_midfill();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
